// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/reset run control for the stopwatch counter chain: button
// edge detection, run-state FSM and the clk/DIV count-enable prescaler.
module stopwatch_ctrl #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic aclr,
    input  logic start_stop,
    input  logic lap_reset,
    output logic enable,
    output logic clr,
    output logic freeze,
    output logic running
);

    localparam int N = $clog2(DIV);
    localparam logic [N-1:0] PS_LAST = N'(DIV - 1);
    localparam logic [N-1:0] PS_ONE  = N'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAP,
        S_STOP
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     ss_sync_q, ss_sync_d;
    logic [2:0]     lr_sync_q, lr_sync_d;
    logic [N-1:0]   prescale_q, prescale_d;
    logic           start_q, start_d;
    logic           enable_q, enable_d;
    logic           clr_q, clr_d;
    logic           freeze_q, freeze_d;
    logic           running_q, running_d;

    logic           ss_press;
    logic           lr_press;
    logic           active_now;
    logic           active_next;

    // NOTE: every flop gets a value in the reset branch and is assigned with <=.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q    <= S_IDLE;
            ss_sync_q  <= '0;
            lr_sync_q  <= '0;
            prescale_q <= '0;
            start_q    <= 1'b0;
            enable_q   <= 1'b0;
            clr_q      <= 1'b0;
            freeze_q   <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ss_sync_q  <= ss_sync_d;
            lr_sync_q  <= lr_sync_d;
            prescale_q <= prescale_d;
            start_q    <= start_d;
            enable_q   <= enable_d;
            clr_q      <= clr_d;
            freeze_q   <= freeze_d;
            running_q  <= running_d;
        end
    end

    // Bit 0/1 form the synchronizer; bit 2 is the delay stage for edge detection.
    always_comb begin
        ss_sync_d = {ss_sync_q[1:0], start_stop};
        lr_sync_d = {lr_sync_q[1:0], lap_reset};
        ss_press  = ss_sync_q[1] & ~ss_sync_q[2];
        lr_press  = lr_sync_q[1] & ~lr_sync_q[2];
    end

    // NOTE: defaults are assigned first so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ss_press) begin
                    state_d = S_RUN;
                end else if (lr_press) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (ss_press)      state_d = S_STOP;
                else if (lr_press) state_d = S_LAP;
            end
            S_LAP: begin
                if (ss_press)      state_d = S_STOP;
                else if (lr_press) state_d = S_RUN;
            end
            S_STOP: begin
                if (ss_press) begin
                    state_d = S_RUN;
                end else if (lr_press) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A fresh start spends one extra cycle at zero; a resume from STOP does not.
    always_comb begin
        active_now  = (state_q == S_RUN) || (state_q == S_LAP);
        active_next = (state_d == S_RUN) || (state_d == S_LAP);
        start_d     = (state_q == S_IDLE) && (state_d == S_RUN);
        prescale_d  = prescale_q;
        enable_d    = 1'b0;
        if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
            prescale_d = '0;
        end else if (active_now && active_next && !start_q) begin
            if (prescale_q == PS_LAST) begin
                prescale_d = '0;
                enable_d   = 1'b1;
            end else begin
                prescale_d = prescale_q + PS_ONE;
            end
        end
        freeze_d  = (state_d == S_LAP);
        running_d = active_next;
    end

    assign enable  = enable_q;
    assign clr     = clr_q;
    assign freeze  = freeze_q;
    assign running = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=4: reset, tick cadence,
// pause/resume phase, lap, clear path, simultaneous presses, async reset.
module tb_stopwatch_ctrl;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic aclr;
    logic start_stop;
    logic lap_reset;
    logic enable;
    logic clr;
    logic freeze;
    logic running;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    stopwatch_ctrl #(.DIV(DIV)) dut (
        .clk        (clk),
        .aclr       (aclr),
        .start_stop (start_stop),
        .lap_reset  (lap_reset),
        .enable     (enable),
        .clr        (clr),
        .freeze     (freeze),
        .running    (running)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge; cyc counts rising edges since the last start.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // First tick DIV+1 edges after a start from IDLE, then every DIV edges.
    function automatic logic exp_tick(input int k);
        return (k >= DIV + 1) && (((k - DIV - 1) % DIV) == 0);
    endfunction

    // Hold the button(s) high through E0..E2; returns just after E2.
    task automatic press(input logic ss, input logic lr);
        if (ss) start_stop = 1'b1;
        if (lr) lap_reset  = 1'b1;
        repeat (3) step();
        start_stop = 1'b0;
        lap_reset  = 1'b0;
    endtask

    task automatic do_reset();
        aclr       = 1'b0;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        step();
        step();
        aclr = 1'b1;
        step();
    endtask

    task automatic start_run();
        press(1'b1, 1'b0);
        cyc = 0;
    endtask

    task automatic test_reset();
        aclr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start_stop = 1'($urandom_range(0, 1));
            lap_reset  = 1'($urandom_range(0, 1));
            step();
            n_checks++;
            if ({enable, clr, freeze, running} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold: outputs=%b expected 0000", {enable, clr, freeze, running});
            end
        end
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        step();
        aclr = 1'b1;
        step();
        n_checks++;
        if ({enable, clr, freeze, running} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: outputs=%b expected 0000", {enable, clr, freeze, running});
        end
        start_run();
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: running=%b expected 1", running);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (enable !== exp_tick(cyc)) begin
                n_fail++;
                $display("FAIL first_tick cyc=%0d: enable=%b expected %b", cyc, enable, exp_tick(cyc));
            end
        end
    endtask

    task automatic test_tick_cadence();
        int pulses;
        do_reset();
        start_run();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (enable === 1'b1) pulses++;
            n_checks++;
            if (enable !== exp_tick(cyc) || clr !== 1'b0 || running !== 1'b1) begin
                n_fail++;
                $display("FAIL cadence cyc=%0d: enable=%b clr=%b running=%b expected %b 0 1",
                         cyc, enable, clr, running, exp_tick(cyc));
            end
        end
        n_checks++;
        if (pulses != 9) begin
            n_fail++;
            $display("FAIL cadence_count: pulses=%0d expected 9", pulses);
        end
    endtask

    task automatic test_pause_resume();
        do_reset();
        start_run();
        // Prescaler is 0,0,1,2 after edges 0..3, so a stop landing on edge 4 holds 2.
        step();
        press(1'b1, 1'b0);
        n_checks++;
        if (running !== 1'b0 || dut.prescale_q !== 2'd2) begin
            n_fail++;
            $display("FAIL pause_entry: running=%b prescale=%0d expected 0 2", running, dut.prescale_q);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (enable !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_no_tick: enable=%b expected 0", enable);
            end
        end
        n_checks++;
        if (dut.prescale_q !== 2'd2) begin
            n_fail++;
            $display("FAIL pause_hold: prescale=%0d expected 2", dut.prescale_q);
        end
        press(1'b1, 1'b0);
        n_checks++;
        if (running !== 1'b1 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL resume: running=%b enable=%b expected 1 0", running, enable);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            n_checks++;
            if (enable !== ((i == 2) || (i == 6))) begin
                n_fail++;
                $display("FAIL resume_tick +%0d: enable=%b expected %b", i, enable, (i == 2) || (i == 6));
            end
        end
    endtask

    task automatic test_lap();
        do_reset();
        start_run();
        press(1'b0, 1'b1);
        n_checks++;
        if (freeze !== 1'b1 || running !== 1'b1 || clr !== 1'b0) begin
            n_fail++;
            $display("FAIL lap_entry: freeze=%b running=%b clr=%b expected 1 1 0", freeze, running, clr);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (enable !== exp_tick(cyc) || freeze !== 1'b1) begin
                n_fail++;
                $display("FAIL lap_cadence cyc=%0d: enable=%b freeze=%b expected %b 1",
                         cyc, enable, freeze, exp_tick(cyc));
            end
        end
        press(1'b0, 1'b1);
        n_checks++;
        if (freeze !== 1'b0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_exit: freeze=%b running=%b expected 0 1", freeze, running);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (enable !== exp_tick(cyc) || freeze !== 1'b0) begin
                n_fail++;
                $display("FAIL lap_exit_cadence cyc=%0d: enable=%b freeze=%b expected %b 0",
                         cyc, enable, freeze, exp_tick(cyc));
            end
        end
        press(1'b0, 1'b1);
        n_checks++;
        if (freeze !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_again: freeze=%b expected 1", freeze);
        end
        // Leave LAP on edge 37, where the prescaler sits at DIV-1: the tick must be dropped.
        repeat (5) step();
        press(1'b1, 1'b0);
        n_checks++;
        if (freeze !== 1'b0 || running !== 1'b0 || enable !== 1'b0 || dut.prescale_q !== 2'd3) begin
            n_fail++;
            $display("FAIL lap_to_stop cyc=%0d: freeze=%b running=%b enable=%b prescale=%0d expected 0 0 0 3",
                     cyc, freeze, running, enable, dut.prescale_q);
        end
    endtask

    task automatic test_clear_path();
        do_reset();
        start_run();
        step();
        step();
        press(1'b1, 1'b0);
        step();
        step();
        press(1'b0, 1'b1);
        n_checks++;
        if (clr !== 1'b1 || running !== 1'b0 || freeze !== 1'b0 || dut.prescale_q !== 2'd0) begin
            n_fail++;
            $display("FAIL stop_to_idle: clr=%b running=%b freeze=%b prescale=%0d expected 1 0 0 0",
                     clr, running, freeze, dut.prescale_q);
        end
        step();
        n_checks++;
        if (clr !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_width: clr=%b expected 0", clr);
        end
        step();
        step();
        press(1'b0, 1'b1);
        n_checks++;
        if (clr !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_to_idle: clr=%b running=%b expected 1 0", clr, running);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (clr !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_clr_width: clr=%b expected 0", clr);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        start_run();
        repeat (3) step();
        press(1'b1, 1'b1);
        n_checks++;
        if (running !== 1'b0 || freeze !== 1'b0 || clr !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_press: running=%b freeze=%b clr=%b expected 0 0 0", running, freeze, clr);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({enable, clr, freeze, running} !== 4'b0000) begin
                n_fail++;
                $display("FAIL simul_no_queue: outputs=%b expected 0000", {enable, clr, freeze, running});
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_run();
        repeat (5) step();
        n_checks++;
        if (enable !== 1'b1 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_async: enable=%b running=%b expected 1 1", enable, running);
        end
        #1 aclr = 1'b0;
        #1;
        n_checks++;
        if ({enable, clr, freeze, running} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: outputs=%b expected 0000", {enable, clr, freeze, running});
        end
        step();
        aclr = 1'b1;
        step();
    endtask

    initial begin
        aclr       = 1'b0;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        test_reset();
        test_tick_cadence();
        test_pause_resume();
        test_lap();
        test_clear_path();
        test_simultaneous();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
